// File: rtl/apb_pkg.sv
// Shared APB definitions for the slave-memory fabric: bus widths, select
// count, slave FSM encoding and the address-window helper.
package apb_pkg;

  localparam int APB_AW  = 32;
  localparam int APB_DW  = 32;
  localparam int NUM_SEL = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_e;

  // True when addr falls inside [base, base + depth*4 - 1]. Computed as an
  // offset compare so a window ending at the top of the map cannot wrap.
  function automatic logic in_range(input logic [APB_AW-1:0] addr,
                                    input logic [APB_AW-1:0] base,
                                    input int unsigned       depth);
    logic [APB_AW-1:0] off;
    off = addr - base;
    return (addr >= base) && (off < APB_AW'(depth * 4));
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 32 word storage: async clear, one synchronous write port and one
// combinational read port.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              PRESET,
  input  logic              we,
  input  logic [IW-1:0]     widx,
  input  logic [APB_DW-1:0] wdata,
  input  logic [IW-1:0]     ridx,
  output logic [APB_DW-1:0] rdata
);

  logic [APB_DW-1:0] mem [DEPTH];

  // Storage: whole array clears on reset, single word written per cycle.
  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave register file behind the AHB-to-APB bridge. One PSEL bit selects
// it; the transfer runs setup -> WAIT_CYCLES wait states -> one READY cycle.
// Read data is captured on entry to READY, writes commit as READY ends.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int                SEL_IDX     = 0,
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 0,
  localparam int               IW          = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               PRESET,
  input  logic [NUM_SEL-1:0] PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [APB_AW-1:0]  PADDR,
  input  logic [APB_DW-1:0]  PWDATA,
  output logic [APB_DW-1:0]  PRDATA,
  output logic               PREADY
);

  apb_slv_state_e    state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic              lat_rng;
  logic [IW-1:0]     lat_idx;
  logic [APB_DW-1:0] lat_wdata;

  logic              sel;
  logic              cur_rng;
  logic [IW-1:0]     cur_idx;
  logic [IW-1:0]     ridx;
  logic              rng;
  logic [APB_DW-1:0] rdata;
  logic [APB_DW-1:0] rd_val;
  logic              we;
  logic              unused_sel;

  assign sel     = PSEL[SEL_IDX];
  assign cur_idx = PADDR[IW+1:2];
  assign cur_rng = in_range(PADDR, BASE_ADDR, DEPTH);

  // With zero wait states READY is entered straight from the setup cycle, so
  // the read port must see the live address there; later it uses the latch.
  assign ridx   = (state == IDLE) ? cur_idx : lat_idx;
  assign rng    = (state == IDLE) ? cur_rng : lat_rng;
  assign rd_val = rng ? rdata : '0;

  // Commit only if the master still holds the access through READY.
  assign we = (state == READY) && sel && PENABLE && lat_write && lat_rng;

  assign unused_sel = ^PSEL;

  apb_slave_regfile #(.DEPTH(DEPTH)) u_rf (
    .CLK    (CLK),
    .PRESET (PRESET),
    .we     (we),
    .widx   (lat_idx),
    .wdata  (lat_wdata),
    .ridx   (ridx),
    .rdata  (rdata)
  );

  // Transfer FSM, wait counter, setup latches and registered outputs.
  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_rng   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          PREADY <= 1'b0;
          if (sel && !PENABLE) begin
            lat_write <= PWRITE;
            lat_rng   <= cur_rng;
            lat_idx   <= cur_idx;
            lat_wdata <= PWDATA;
            cnt       <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state  <= READY;
              PREADY <= 1'b1;
              if (!PWRITE) PRDATA <= rd_val;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!sel) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state  <= READY;
              PREADY <= 1'b1;
              if (!lat_write) PRDATA <= rd_val;
            end
          end
        end
        READY: begin
          state  <= IDLE;
          PREADY <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          PREADY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Four-slave fabric (one per PSEL bit) with mixed wait states, driven by
// directed APB transfers; read results go through an expected-data queue.
module tb_apb_slave_mem;

  localparam int WC [4] = '{0, 3, 0, 4};

  logic              CLK = 1'b0;
  logic              PRESET;
  logic [3:0]        PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic [3:0]        pready;
  logic [3:0][31:0]  prdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model  [4][16];
  logic [31:0] last_rd [4];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_slv
    apb_slave_mem #(
      .SEL_IDX     (g),
      .BASE_ADDR   (32'(g) << 12),
      .DEPTH       (16),
      .WAIT_CYCLES (WC[g])
    ) dut (
      .CLK     (CLK),
      .PRESET  (PRESET),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave s owns 0xs000..0xs03F.
  function automatic logic hit(input int s, input logic [31:0] a);
    return (a[31:12] == 20'(s)) && (a[11:0] < 12'h040);
  endfunction

  function automatic logic [31:0] model_rd(input int s, input logic [31:0] a);
    return hit(s, a) ? model[s][a[5:2]] : 32'h0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      last_rd[i] = '0;
      for (int j = 0; j < 16; j++) model[i][j] = '0;
    end
  endtask

  task automatic idle();
    @(negedge CLK);
    PSEL    = 4'b0000;
    PENABLE = 1'b0;
  endtask

  // One full transfer to slave s; returns right after the READY cycle is
  // sampled so a following call produces a back-to-back setup.
  task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd);
    int          n;
    logic        stray;
    logic [3:0]  me;
    exp_t        e;
    me = 4'(1 << s);
    @(negedge CLK);
    PSEL    = me;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wd;
    if (!wr) sb.push_back('{inst: s, data: model_rd(s, addr)});
    @(negedge CLK);
    PENABLE = 1'b1;
    #1;
    n     = 0;
    stray = |(pready & ~me);
    while (!pready[s] && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
      stray |= |(pready & ~me);
    end
    chk("latency", 32'(n), 32'(WC[s]));
    chk("stray_pready", 32'(stray), 32'h0);
    if (!wr) begin
      e = sb.pop_front();
      chk("rdata", prdata[e.inst], e.data);
      last_rd[e.inst] = e.data;
    end else begin
      chk("wr_prdata_hold", prdata[s], last_rd[s]);
      if (hit(s, addr)) model[s][addr[5:2]] = wd;
    end
  endtask

  initial begin
    logic seen;
    PRESET  = 1'b1;
    PSEL    = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    clear_model();
    repeat (2) @(negedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_pready", 32'(pready[i]), 32'h0);
      chk("reset_prdata", prdata[i], 32'h0);
    end
    @(negedge CLK);
    PRESET = 1'b0;

    // Zero-wait write then read back.
    xfer(0, 1'b1, 32'h0000_0008, 32'hA5A5_1234);
    xfer(0, 1'b0, 32'h0000_0008, 32'h0);
    chk("zw_rdata_const", prdata[0], 32'hA5A5_1234);
    idle();

    // Three wait states, freshly reset word.
    xfer(1, 1'b0, 32'h0000_1004, 32'h0);
    idle();

    // Out-of-range write aliases idx 0 but must be dropped.
    xfer(0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF);
    xfer(0, 1'b0, 32'h0000_0040, 32'h0);
    xfer(0, 1'b0, 32'h0000_0000, 32'h0);
    idle();

    // Select isolation: slave 2 must ignore a PSEL[0] write to its window.
    xfer(0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
    xfer(2, 1'b0, 32'h0000_2000, 32'h0);
    idle();

    // Back-to-back write then read of the same word.
    xfer(0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    xfer(0, 1'b0, 32'h0000_0010, 32'h0);
    idle();

    // Abort: drop PSEL in the second wait cycle of a 4-wait write.
    xfer(3, 1'b1, 32'h0000_300C, 32'h0BAD_0001);
    idle();
    @(negedge CLK);
    PSEL = 4'b1000; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h0000_300C; PWDATA = 32'h1111_2222;
    @(negedge CLK);
    PENABLE = 1'b1;
    @(negedge CLK);
    PSEL = 4'b0000; PENABLE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      #1;
      seen |= pready[3];
    end
    chk("abort_pready", 32'(seen), 32'h0);
    chk("abort_prdata", prdata[3], last_rd[3]);
    xfer(3, 1'b0, 32'h0000_300C, 32'h0);
    idle();

    // PENABLE with select but no setup: stays idle.
    @(negedge CLK);
    PSEL = 4'b0001; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0000_0008;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      seen |= pready[0];
    end
    chk("no_setup_pready", 32'(seen), 32'h0);
    idle();

    // Reset in the middle of a waited transfer.
    xfer(1, 1'b1, 32'h0000_1008, 32'h0000_CAFE);
    xfer(1, 1'b0, 32'h0000_1008, 32'h0);
    idle();
    @(negedge CLK);
    PSEL = 4'b0010; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h0000_1008; PWDATA = 32'h0000_0001;
    @(negedge CLK);
    PENABLE = 1'b1;
    @(negedge CLK);
    #2;
    PRESET = 1'b1;
    #1;
    chk("rst_async_pready", 32'(pready[1]), 32'h0);
    for (int i = 0; i < 4; i++) chk("rst_async_prdata", prdata[i], 32'h0);
    clear_model();
    @(negedge CLK);
    PRESET = 1'b0; PSEL = 4'b0000; PENABLE = 1'b0;
    xfer(1, 1'b0, 32'h0000_1008, 32'h0);
    xfer(0, 1'b0, 32'h0000_0008, 32'h0);
    idle();

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
